// File: rtl/bram_data_loader_pkg.sv
// ---------------------------------------------------------------------------
// bram_data_loader_pkg
// Shared definitions for the BRAM data loader.
//   BYTE_WIDTH : width of one CPU stream byte
//   state_t    : loader FSM states
// ---------------------------------------------------------------------------
package bram_data_loader_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTART = 2'd1,
        RECEIVE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/bram_data_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// bram_data_loader_byte_packer
// Collects CPU bytes into a data_width_in_byte-byte word, little-endian
// (first byte of a word lands in the least significant byte lane).
//
// Optional feature macro: BRAM_DATA_LOADER_PARTIAL_FLUSH_EN
//   defined   : flush with a partially filled word emits it, upper lanes zero
//   undefined : flush silently drops a partial word
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   drop any partial word and restart at lane 0
//   accept     in   byte_in is taken this cycle
//   flush      in   end of stream; partial word handled per macro above
//   byte_in    in   data byte
//   word       out  last completed word, held until the next one
//   word_valid out  1-cycle pulse, the cycle after a word completes
//   word_fire  out  combinational: a word completes in this cycle
// ---------------------------------------------------------------------------
module bram_data_loader_byte_packer
    import bram_data_loader_pkg::*;
#(
    parameter int data_width_in_byte = 3
)
(
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clear,
    input  logic                                     accept,
    input  logic                                     flush,
    input  logic [BYTE_WIDTH-1:0]                    byte_in,
    output logic [BYTE_WIDTH*data_width_in_byte-1:0] word,
    output logic                                     word_valid,
    output logic                                     word_fire
);

    localparam int WORD_W = BYTE_WIDTH * data_width_in_byte;
    localparam int CW     = (data_width_in_byte > 1) ? $clog2(data_width_in_byte) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(data_width_in_byte - 1);

    logic [CW-1:0]     count_reg;
    logic [WORD_W-1:0] acc_reg;
    logic [WORD_W-1:0] acc_next;
    logic [WORD_W-1:0] word_reg;
    logic              word_valid_reg;
    logic              last_byte;

    // The accumulator is cleared after every word, so lanes not yet
    // written are already zero: a partial word comes out zero-padded.
    genvar gi;
    generate
        for (gi = 0; gi < data_width_in_byte; gi++) begin : g_lane
            assign acc_next[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                (accept && (count_reg == CW'(gi))) ? byte_in
                                                   : acc_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    assign last_byte = accept && (count_reg == LAST_LANE);

`ifdef BRAM_DATA_LOADER_PARTIAL_FLUSH_EN
    logic partial_pending;
    // A byte accepted in the flush cycle counts toward the partial word.
    assign partial_pending = flush && !last_byte && (accept || (count_reg != '0));
    assign word_fire       = last_byte || partial_pending;
`else
    assign word_fire       = last_byte;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg      <= '0;
            acc_reg        <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= word_fire;
            if (word_fire) begin
                word_reg <= acc_next;
            end
            if (clear || flush || word_fire) begin
                count_reg <= '0;
                acc_reg   <= '0;
            end else if (accept) begin
                count_reg <= count_reg + 1'b1;
                acc_reg   <= acc_next;
            end
        end
    end

    assign word       = word_reg;
    assign word_valid = word_valid_reg;

endmodule

// File: rtl/bram_data_loader.sv
// ---------------------------------------------------------------------------
// bram_data_loader
// Loads a song data block from the CPU byte stream into a BRAM write port.
// sig_on starts a load: restart is held for restarting_timeout cycles, then
// bytes are accepted on data_ready, packed into words and written at
// incrementing addresses. sig_done pulses once all writes are out.
//
// Optional feature macro: BRAM_DATA_LOADER_PARTIAL_FLUSH_EN
//   defined   : trailing partial word is zero-padded and written
//   undefined : trailing partial word is discarded
//
// Ports
//   CLK, RESET_L       clock / asynchronous active-low reset
//   bram_addr_w        BRAM write address (held between writes)
//   bram_data_in       BRAM write data (held between writes)
//   bram_en_w          1-cycle write pulse per word
//   sig_on             start pulse (ignored unless idle)
//   sig_done           1-cycle completion pulse
//   restart            CPU restart request level
//   init_index         song index latched at start
//   init_aux_info      constant static_init_aux_info
//   request_data       high while bytes are accepted
//   data_ready         byte strobe for cpu_data_in
//   cpu_data_in        CPU data byte
//   transmit_finished  CPU end-of-stream
//   song_selection     song to load
// ---------------------------------------------------------------------------
module bram_data_loader
    import bram_data_loader_pkg::*;
#(
    parameter int         addr_width           = 13,
    parameter int         data_width_in_byte   = 3,
    parameter logic [7:0] static_init_aux_info = 8'b00000000,
    parameter int         restarting_timeout   = 5
)
(
    input  logic                                     CLK,
    input  logic                                     RESET_L,
    output logic [addr_width-1:0]                    bram_addr_w,
    output logic [BYTE_WIDTH*data_width_in_byte-1:0] bram_data_in,
    output logic                                     bram_en_w,
    input  logic                                     sig_on,
    output logic                                     sig_done,
    output logic                                     restart,
    output logic [7:0]                               init_index,
    output logic [7:0]                               init_aux_info,
    output logic                                     request_data,
    input  logic                                     data_ready,
    input  logic [7:0]                               cpu_data_in,
    input  logic                                     transmit_finished,
    input  logic [7:0]                               song_selection
);

    localparam int WORD_W = BYTE_WIDTH * data_width_in_byte;
    localparam int TW     = (restarting_timeout > 1) ? $clog2(restarting_timeout) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(restarting_timeout - 1);

    state_t              state_reg;
    state_t              state_next;
    logic [TW-1:0]       tmo_reg;
    logic [addr_width-1:0] addr_cnt_reg;
    logic [addr_width-1:0] addr_out_reg;
    logic [7:0]          init_index_reg;

    logic                pk_clear;
    logic                pk_accept;
    logic                pk_flush;
    logic                pk_valid;
    logic                pk_fire;
    logic [WORD_W-1:0]   pk_word;

    bram_data_loader_byte_packer #(
        .data_width_in_byte (data_width_in_byte)
    ) u_packer (
        .clk        (CLK),
        .rst_n      (RESET_L),
        .clear      (pk_clear),
        .accept     (pk_accept),
        .flush      (pk_flush),
        .byte_in    (cpu_data_in),
        .word       (pk_word),
        .word_valid (pk_valid),
        .word_fire  (pk_fire)
    );

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counts cycles spent in RESTART; zero on entry.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            tmo_reg <= '0;
        end else if (state_reg != RESTART) begin
            tmo_reg <= '0;
        end else begin
            tmo_reg <= tmo_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            init_index_reg <= 8'd0;
        end else if ((state_reg == IDLE) && sig_on) begin
            init_index_reg <= song_selection;
        end
    end

    // addr_out_reg captures the word address in the same cycle the packer
    // registers the word, so both appear together with bram_en_w and hold
    // afterwards. The running address wraps naturally at 2^addr_width.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            addr_cnt_reg <= '0;
            addr_out_reg <= '0;
        end else if (pk_clear) begin
            addr_cnt_reg <= '0;
        end else if (pk_fire) begin
            addr_out_reg <= addr_cnt_reg;
            addr_cnt_reg <= addr_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pk_clear     = 1'b0;
        pk_accept    = 1'b0;
        pk_flush     = 1'b0;
        restart      = 1'b0;
        request_data = 1'b0;
        sig_done     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sig_on) begin
                    pk_clear   = 1'b1;
                    state_next = RESTART;
                end
            end
            RESTART: begin
                restart = 1'b1;
                if (tmo_reg == TMO_LAST) begin
                    state_next = RECEIVE;
                end
            end
            RECEIVE: begin
                request_data = 1'b1;
                pk_accept    = data_ready;
                if (transmit_finished) begin
                    pk_flush   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // A word completed in the finishing cycle is written in the
                // first DONE cycle; completion is reported after it.
                if (!pk_valid) begin
                    sig_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bram_addr_w   = addr_out_reg;
    assign bram_data_in  = pk_word;
    assign bram_en_w     = pk_valid;
    assign init_index    = init_index_reg;
    assign init_aux_info = static_init_aux_info;

endmodule

// File: tb/tb_bram_data_loader.sv
module tb_bram_data_loader;

    localparam int         AW  = 13;
    localparam int         NB  = 3;
    localparam int         WW  = 8 * NB;
    localparam int         TMO = 5;
    localparam logic [7:0] AUX = 8'h5A;

    logic          CLK = 1'b0;
    logic          RESET_L;
    logic [AW-1:0] bram_addr_w;
    logic [WW-1:0] bram_data_in;
    logic          bram_en_w;
    logic          sig_on;
    logic          sig_done;
    logic          restart;
    logic [7:0]    init_index;
    logic [7:0]    init_aux_info;
    logic          request_data;
    logic          data_ready;
    logic [7:0]    cpu_data_in;
    logic          transmit_finished;
    logic [7:0]    song_selection;

    always #5 CLK = ~CLK;

    bram_data_loader #(
        .addr_width           (AW),
        .data_width_in_byte   (NB),
        .static_init_aux_info (AUX),
        .restarting_timeout   (TMO)
    ) dut (
        .CLK               (CLK),
        .RESET_L           (RESET_L),
        .bram_addr_w       (bram_addr_w),
        .bram_data_in      (bram_data_in),
        .bram_en_w         (bram_en_w),
        .sig_on            (sig_on),
        .sig_done          (sig_done),
        .restart           (restart),
        .init_index        (init_index),
        .init_aux_info     (init_aux_info),
        .request_data      (request_data),
        .data_ready        (data_ready),
        .cpu_data_in       (cpu_data_in),
        .transmit_finished (transmit_finished),
        .song_selection    (song_selection)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int restart_cnt = 0;
    int done_cnt = 0;
    int done_cycle = 0;
    int last_en_cycle = -1;

    logic [AW-1:0] obs_addr[$];
    logic [WW-1:0] obs_data[$];
    logic [7:0]    model_bytes[$];

    // Observer: samples outputs on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            cyc = cyc + 1;
            if (restart) restart_cnt = restart_cnt + 1;
            if (sig_done) begin
                done_cnt   = done_cnt + 1;
                done_cycle = cyc;
            end
            if (bram_en_w) begin
                obs_addr.push_back(bram_addr_w);
                obs_data.push_back(bram_data_in);
                last_en_cycle = cyc;
                $display("[%0d] write addr=%0d data=%06h", cyc, bram_addr_w, bram_data_in);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: consecutive groups of NB accepted bytes form words,
    // little-endian, at addresses 0,1,2,... A trailing partial group is
    // zero-padded and written only with the flush feature.
    function automatic logic [WW-1:0] model_word(input int k);
        logic [WW-1:0] w;
        w = '0;
        for (int j = 0; j < NB; j++) begin
            if (k * NB + j < model_bytes.size()) w[j*8 +: 8] = model_bytes[k*NB + j];
        end
        return w;
    endfunction

    function automatic int model_count();
        int n;
        n = model_bytes.size() / NB;
`ifdef BRAM_DATA_LOADER_PARTIAL_FLUSH_EN
        if (model_bytes.size() % NB != 0) n = n + 1;
`endif
        return n;
    endfunction

    // Pulses sig_on, pokes a data_ready during RESTART (must be ignored) and
    // waits for request_data. Caller is positioned at a falling edge.
    task automatic start_load(input logic [7:0] song, output bit ok);
        model_bytes.delete();
        obs_addr.delete();
        obs_data.delete();
        done_cnt      = 0;
        restart_cnt   = 0;
        last_en_cycle = -1;
        ok            = 1'b0;
        sig_on         = 1'b1;
        song_selection = song;
        @(negedge CLK);
        sig_on         = 1'b0;
        song_selection = 8'($urandom);
        data_ready     = 1'b1;
        cpu_data_in    = 8'hEE;
        @(negedge CLK);
        data_ready     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (request_data) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic send_bytes(input int n, input int gmin, input int gmax,
                              input bit fin_last, input bit stray_on, input bit fixed);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = fixed ? 8'(i + 1) : 8'($urandom);
            data_ready        = 1'b1;
            cpu_data_in       = b;
            transmit_finished = fin_last && (i == n - 1);
            sig_on            = stray_on && (i == 0);
            model_bytes.push_back(b);
            @(negedge CLK);
            data_ready        = 1'b0;
            transmit_finished = 1'b0;
            sig_on            = 1'b0;
            repeat ($urandom_range(gmax, gmin)) @(negedge CLK);
        end
    endtask

    task automatic finish_pulse();
        transmit_finished = 1'b1;
        @(negedge CLK);
        transmit_finished = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET_L = 1'b0;
        repeat (10) @(negedge CLK);
        checks++; if (bram_addr_w !== '0) begin errors++; $display("FAIL reset_addr got %0h want 0", bram_addr_w); end
        checks++; if (bram_data_in !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", bram_data_in); end
        checks++; if (bram_en_w !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", bram_en_w); end
        checks++; if (sig_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", sig_done); end
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL reset_restart got %b want 0", restart); end
        checks++; if (request_data !== 1'b0) begin errors++; $display("FAIL reset_request got %b want 0", request_data); end
        checks++; if (init_index !== 8'd0) begin errors++; $display("FAIL reset_index got %0h want 0", init_index); end
        checks++; if (init_aux_info !== AUX) begin errors++; $display("FAIL reset_aux got %0h want %0h", init_aux_info, AUX); end
        RESET_L = 1'b1;
        @(negedge CLK);
        $display("test_reset done");
    endtask

    task automatic test_fixed_stream();
        bit ok;
        logic [WW-1:0] exp_w [4];
        exp_w = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
        start_load(8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fixed_request got timeout want request_data"); end
        checks++; if (restart_cnt != TMO) begin errors++; $display("FAIL fixed_restart_len got %0d want %0d", restart_cnt, TMO); end
        checks++; if (init_index !== 8'd0) begin errors++; $display("FAIL fixed_index got %0h want 0", init_index); end
        send_bytes(12, 1, 12, 1'b0, 1'b0, 1'b1);
        finish_pulse();
        wait_done(ok);
        checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL fixed_done got %0d pulses want 1", done_cnt); end
        checks++; if (request_data !== 1'b0) begin errors++; $display("FAIL fixed_idle_request got %b want 0", request_data); end
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL fixed_count got %0d want 4", obs_addr.size()); end
        for (int k = 0; k < 4 && k < obs_addr.size(); k++) begin
            checks++;
            if (obs_addr[k] !== AW'(k) || obs_data[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL fixed_write%0d got %0d/%06h want %0d/%06h", k, obs_addr[k], obs_data[k], k, exp_w[k]);
            end
        end
        checks++; if (bram_addr_w !== AW'(3) || bram_data_in !== 24'h0C0B0A) begin
            errors++; $display("FAIL fixed_hold got %0d/%06h want 3/0c0b0a", bram_addr_w, bram_data_in);
        end
        checks++; if (done_cycle <= last_en_cycle) begin errors++; $display("FAIL fixed_done_order got %0d want >%0d", done_cycle, last_en_cycle); end
        $display("test_fixed_stream done");
    endtask

    task automatic test_partial();
        bit ok;
        logic [7:0] song;
        song = 8'($urandom);
        start_load(song, ok);
        checks++; if (!ok) begin errors++; $display("FAIL partial_request got timeout want request_data"); end
        checks++; if (init_index !== song) begin errors++; $display("FAIL partial_index got %0h want %0h", init_index, song); end
        send_bytes(4, 1, 3, 1'b0, 1'b0, 1'b0);
        finish_pulse();
        wait_done(ok);
        checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL partial_done got %0d pulses want 1", done_cnt); end
        checks++; if (obs_addr.size() != model_count()) begin
            errors++; $display("FAIL partial_count got %0d want %0d", obs_addr.size(), model_count());
        end
        for (int k = 0; k < obs_addr.size() && k < model_count(); k++) begin
            checks++;
            if (obs_addr[k] !== AW'(k) || obs_data[k] !== model_word(k)) begin
                errors++;
                $display("FAIL partial_write%0d got %0d/%06h want %0d/%06h", k, obs_addr[k], obs_data[k], k, model_word(k));
            end
        end
`ifdef BRAM_DATA_LOADER_PARTIAL_FLUSH_EN
        checks++; if (done_cycle != last_en_cycle + 1) begin errors++; $display("FAIL partial_done_time got %0d want %0d", done_cycle, last_en_cycle + 1); end
`else
        checks++; if (done_cycle <= last_en_cycle) begin errors++; $display("FAIL partial_done_order got %0d want >%0d", done_cycle, last_en_cycle); end
`endif
        $display("test_partial done");
    endtask

    task automatic test_finish_same_cycle();
        bit ok;
        for (int r = 0; r < 3; r++) begin
            int n;
            n = (r == 0) ? 6 : $urandom_range(10, 1);
            start_load(8'($urandom), ok);
            checks++; if (!ok) begin errors++; $display("FAIL same_request%0d got timeout want request_data", r); end
            send_bytes(n, 0, 2, 1'b1, 1'b0, 1'b0);
            wait_done(ok);
            checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL same_done%0d got %0d pulses want 1", r, done_cnt); end
            checks++; if (obs_addr.size() != model_count()) begin
                errors++; $display("FAIL same_count%0d got %0d want %0d", r, obs_addr.size(), model_count());
            end
            for (int k = 0; k < obs_addr.size() && k < model_count(); k++) begin
                checks++;
                if (obs_addr[k] !== AW'(k) || obs_data[k] !== model_word(k)) begin
                    errors++;
                    $display("FAIL same_write%0d_%0d got %0d/%06h want %0d/%06h", r, k, obs_addr[k], obs_data[k], k, model_word(k));
                end
            end
            checks++; if (done_cycle <= last_en_cycle) begin errors++; $display("FAIL same_done_order%0d got %0d want >%0d", r, done_cycle, last_en_cycle); end
        end
        $display("test_finish_same_cycle done");
    endtask

    task automatic test_random_loads();
        bit ok;
        for (int r = 0; r < 4; r++) begin
            int  n;
            bit  fin_last;
            n        = $urandom_range(14, 1);
            fin_last = $urandom_range(1, 0) == 1;
            start_load(8'($urandom), ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_request%0d got timeout want request_data", r); end
            restart_cnt = 0;
            send_bytes(n, 0, 3, fin_last, 1'b1, 1'b0);
            if (!fin_last) finish_pulse();
            wait_done(ok);
            checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL rand_done%0d got %0d pulses want 1", r, done_cnt); end
            checks++; if (restart_cnt != 0) begin errors++; $display("FAIL rand_stray_on%0d got %0d restart cycles want 0", r, restart_cnt); end
            checks++; if (obs_addr.size() != model_count()) begin
                errors++; $display("FAIL rand_count%0d got %0d want %0d", r, obs_addr.size(), model_count());
            end
            for (int k = 0; k < obs_addr.size() && k < model_count(); k++) begin
                checks++;
                if (obs_addr[k] !== AW'(k) || obs_data[k] !== model_word(k)) begin
                    errors++;
                    $display("FAIL rand_write%0d_%0d got %0d/%06h want %0d/%06h", r, k, obs_addr[k], obs_data[k], k, model_word(k));
                end
            end
        end
        $display("test_random_loads done");
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        start_load(8'($urandom), ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_request got timeout want request_data"); end
        send_bytes(5, 1, 1, 1'b0, 1'b0, 1'b0);
        // Sixth byte is presented but reset lands before the sampling edge.
        data_ready  = 1'b1;
        cpu_data_in = 8'($urandom);
        #2;
        RESET_L = 1'b0;
        #1;
        checks++; if (request_data !== 1'b0 || restart !== 1'b0) begin
            errors++; $display("FAIL midrst_state got req=%b rst=%b want 0/0", request_data, restart);
        end
        checks++; if (bram_data_in !== '0 || bram_addr_w !== '0) begin
            errors++; $display("FAIL midrst_outputs got %0d/%06h want 0/000000", bram_addr_w, bram_data_in);
        end
        @(negedge CLK);
        data_ready = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (obs_addr.size() != 1) begin errors++; $display("FAIL midrst_writes got %0d want 1", obs_addr.size()); end
        if (obs_addr.size() > 0) begin
            checks++; if (obs_data[0] !== model_word(0)) begin
                errors++; $display("FAIL midrst_word0 got %06h want %06h", obs_data[0], model_word(0));
            end
        end
        RESET_L = 1'b1;
        @(negedge CLK);
        start_load(8'($urandom), ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_reload got timeout want request_data"); end
        send_bytes(3, 1, 2, 1'b0, 1'b0, 1'b0);
        finish_pulse();
        wait_done(ok);
        checks++; if (obs_addr.size() != 1) begin errors++; $display("FAIL midrst_reload_count got %0d want 1", obs_addr.size()); end
        if (obs_addr.size() > 0) begin
            checks++; if (obs_addr[0] !== AW'(0) || obs_data[0] !== model_word(0)) begin
                errors++; $display("FAIL midrst_reload_write got %0d/%06h want 0/%06h", obs_addr[0], obs_data[0], model_word(0));
            end
        end
        $display("test_reset_mid_load done");
    endtask

    initial begin
        RESET_L           = 1'b0;
        sig_on            = 1'b0;
        data_ready        = 1'b0;
        cpu_data_in       = 8'd0;
        transmit_finished = 1'b0;
        song_selection    = 8'd0;
        @(negedge CLK);
        test_reset();
        test_fixed_stream();
        test_partial();
        test_finish_same_cycle();
        test_random_loads();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
